// File: rtl/inv_round_if.sv
// Handshake bundle for inv_round: input state/key with valid/ready, result with valid/ready.
// lastround exists only when INV_ROUND_LAST_EN is defined; dbg_state mirrors the FSM.
interface inv_round_if;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0][3:0][7:0] roundin;
  logic [3:0][3:0][7:0] key;
`ifdef INV_ROUND_LAST_EN
  logic                 lastround;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0][3:0][7:0] roundout;
  logic [1:0]           dbg_state;

`ifdef INV_ROUND_LAST_EN
  modport master (output in_valid, roundin, key, lastround, out_ready,
                  input  in_ready, out_valid, roundout, dbg_state);
  modport slave  (input  in_valid, roundin, key, lastround, out_ready,
                  output in_ready, out_valid, roundout, dbg_state);
`else
  modport master (output in_valid, roundin, key, out_ready,
                  input  in_ready, out_valid, roundout, dbg_state);
  modport slave  (input  in_valid, roundin, key, out_ready,
                  output in_ready, out_valid, roundout, dbg_state);
`endif
endinterface

// File: rtl/inv_round.sv
// Iterative AES inverse round: InvShiftRows (at load), InvSubBytes+AddRoundKey one column per
// cycle, then InvMixColumns in one cycle. INV_ROUND_LAST_EN adds lastround to skip InvMixColumns.
module inv_round (
  input  logic        clk,
  input  logic        rst,
  inv_round_if.slave  io
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] MIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]           fsm;
  logic [1:0]           col;
  logic [3:0][3:0][7:0] state_q;
  logic [3:0][3:0][7:0] key_q;
  logic [3:0][3:0][7:0] roundout_q;
  logic                 last_q;

  logic [3:0][3:0][7:0] load_state;
  logic [3:0][3:0][7:0] sub_state;
  logic [3:0][3:0][7:0] mix_state;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); zero naturally maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] p;
    sq = a;
    p  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      p  = gf_mul(p, sq);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [3:0][7:0] inv_mix_col(input logic [3:0][7:0] a);
    logic [3:0][7:0] m9, mb, md, me, r_o;
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++)
      r_o[r] = me[2'(r)] ^ mb[2'(r + 1)] ^ md[2'(r + 2)] ^ m9[2'(r + 3)];
    return r_o;
  endfunction

  always_comb begin
    load_state = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        load_state[r][c] = io.roundin[r][2'(c - r)];
  end

  always_comb begin
    sub_state = state_q;
    for (int r = 0; r < 4; r++)
      sub_state[r][col] = inv_sbox(state_q[r][col]) ^ key_q[r][col];
  end

  always_comb begin
    logic [3:0][7:0] cv;
    logic [3:0][7:0] mv;
    mix_state = '0;
    cv        = '0;
    mv        = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) cv[r] = state_q[r][c];
      mv = inv_mix_col(cv);
      for (int r = 0; r < 4; r++) mix_state[r][c] = mv[r];
    end
  end

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and roundout is stable while out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      col        <= 2'd0;
      state_q    <= '0;
      key_q      <= '0;
      roundout_q <= '0;
`ifdef INV_ROUND_LAST_EN
      last_q     <= 1'b0;
`endif
    end else begin
      case (fsm)
        IDLE: if (io.in_valid) begin
          state_q <= load_state;
          key_q   <= io.key;
`ifdef INV_ROUND_LAST_EN
          last_q  <= io.lastround;
`endif
          col     <= 2'd0;
          fsm     <= SUB;
        end
        SUB: begin
          state_q <= sub_state;
          col     <= col + 2'd1;
          if (col == 2'd3) begin
            if (last_q) begin
              roundout_q <= sub_state;
              fsm        <= DONE;
            end else begin
              fsm <= MIX;
            end
          end
        end
        MIX: begin
          state_q    <= mix_state;
          roundout_q <= mix_state;
          fsm        <= DONE;
        end
        default: if (io.out_ready) fsm <= IDLE;
      endcase
    end
  end

`ifndef INV_ROUND_LAST_EN
  assign last_q = 1'b0;
`endif

  assign io.in_ready  = (fsm == IDLE);
  assign io.out_valid = (fsm == DONE);
  assign io.roundout  = roundout_q;
  assign io.dbg_state = fsm;

endmodule

// File: tb/tb_inv_round.sv
// Directed bench for inv_round: table-driven AES inverse-round model, per-cycle output compare,
// latency/handshake/reset checks. Last-round vectors go through the mix path without INV_ROUND_LAST_EN.
module tb_inv_round;
  typedef logic [3:0][3:0][7:0] st_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_round_if io();
  inv_round dut (.clk(clk), .rst(rst), .io(io));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_edge = 0;
  bit prev_valid = 1'b0;
  logic [127:0] exp_q[$];
  int lat_q[$];
  logic [7:0] inv_tab[256];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic hi;
    p = 0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa ^= 8'h1b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  // Forward S-box from brute-force inverse plus forward affine, then inverted into a table.
  task automatic build_tab();
    logic [7:0] inv, s, x8, b8;
    for (int x = 0; x < 256; x++) begin
      x8 = 8'(x);
      inv = 0;
      for (int b = 1; b < 256; b++) begin
        b8 = 8'(b);
        if (gmul(x8, b8) == 8'h01) inv = b8;
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tab[s] = x8;
    end
  endtask

  function automatic st_t model(input st_t rin, input st_t k, input bit last);
    logic [7:0] coef[4];
    logic [7:0] acc;
    st_t s, m;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = inv_tab[rin[r][(c - r + 4) % 4]] ^ k[r][c];
    if (last) return s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 0;
        for (int j = 0; j < 4; j++) acc ^= gmul(coef[(j - r + 4) % 4], s[j][c]);
        m[r][c] = acc;
      end
    return m;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (io.in_valid && io.in_ready) acc_edge = cyc + 1;
      if (io.out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_out_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          chk("roundout", io.roundout, exp_q[0]);
          chk("in_ready_in_done", 128'(io.in_ready), 128'(0));
          if (!prev_valid) chk("latency", 128'(cyc - acc_edge), 128'(lat_q[0]));
          if (io.out_ready) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
          end
        end
      end
      prev_valid = io.out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic bit eff_last(input bit last);
`ifdef INV_ROUND_LAST_EN
    return last;
`else
    return 1'b0;
`endif
  endfunction

  function automatic st_t rnd_st();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_in(input st_t rin, input st_t k, input bit last);
    io.roundin = rin;
    io.key     = k;
`ifdef INV_ROUND_LAST_EN
    io.lastround = last;
`endif
  endtask

  task automatic send(input st_t rin, input st_t k, input bit last);
    int n;
    bit l;
    l = eff_last(last);
    exp_q.push_back(model(rin, k, l));
    lat_q.push_back(l ? 4 : 5);
    @(posedge clk); #1;
    io.in_valid = 1'b1;
    drive_in(rin, k, last);
    n = 0;
    forever begin
      @(negedge clk);
      if (io.in_ready) break;
      n++;
      if (n > 50) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    drive_in(rnd_st(), rnd_st(), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    st_t zero, ones, mixv, mixe, shv, she, e;
    int n, pc;
    zero = '0;
    ones = '1;
    mixv = {{4{8'h65}}, {4{8'h32}}, {4{8'he3}}, {4{8'h19}}};
    mixe = {{4{8'h45}}, {4{8'h53}}, {4{8'h13}}, {4{8'hdb}}};
    shv  = {16{8'h52}};
    shv[1][0] = 8'h63;
    she  = {16{8'h48}};
    she[1][1] = 8'h00;

    rst = 1'b1;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    drive_in(zero, zero, 1'b0);
    build_tab();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(io.out_valid), 128'(0));
    chk("rst_in_ready", 128'(io.in_ready), 128'(1));
    chk("rst_roundout", io.roundout, 128'(0));
    chk("rst_dbg_state", 128'(io.dbg_state), 128'(0));
    rst = 1'b0;

    // Model pins from hand-computed values
    chk("pin_zero_mix", model(zero, zero, 1'b0), {16{8'h52}});
    chk("pin_last_ff", model(zero, ones, 1'b1), {16{8'had}});
    chk("pin_invmix", model(mixv, zero, 1'b0), mixe);
    chk("pin_shiftrows", model(shv, zero, 1'b1), she);

    send(zero, zero, 1'b0); wait_idle();
    send(zero, ones, 1'b1); wait_idle();
    send(mixv, zero, 1'b0); wait_idle();
    send(shv, zero, 1'b1);  wait_idle();
    for (int i = 0; i < 4; i++) send(rnd_st(), rnd_st(), 1'($urandom_range(0, 1)));
    wait_idle();

    // Reset mid-SUB while out_ready is low
    io.out_ready = 1'b0;
    send(mixv, ones, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 128'(io.out_valid), 128'(0));
    chk("midrst_in_ready", 128'(io.in_ready), 128'(1));
    chk("midrst_roundout", io.roundout, 128'(0));
    rst = 1'b0;
    io.out_ready = 1'b1;
    send(shv, ones, 1'b0); wait_idle();

    // Back-pressure for 10 cycles, then out_ready pulse with in_valid already high
    io.out_ready = 1'b0;
    send(mixv, zero, 1'b0);
    n = 0;
    while (!io.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", 128'(io.out_valid), 128'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(io.out_valid), 128'(1));
      chk("bp_in_ready", 128'(io.in_ready), 128'(0));
    end
    @(posedge clk); #1;
    e = rnd_st();
    exp_q.push_back(model(e, ones, 1'b0));
    lat_q.push_back(5);
    io.out_ready = 1'b1;
    io.in_valid  = 1'b1;
    drive_in(e, ones, 1'b0);
    @(negedge clk);
    pc = cyc;
    chk("pulse_in_ready", 128'(io.in_ready), 128'(0));
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    @(negedge clk);
    chk("next_in_ready", 128'(io.in_ready), 128'(1));
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    chk("accept_edge", 128'(acc_edge), 128'(pc + 2));
    io.out_ready = 1'b1;
    wait_idle();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
